tensor_stack: RTL and testbench
===============================

Name: tensor_stack

Overview:
- Hardware LIFO that serves as the control unit's operand stack for PUSH X/Y and POP X/Y.
- Its push side consumes the CPU's stack_out/stack_out_valid. Its top-of-stack side drives the CPU's stack_in/stack_in_valid and accepts stack_in_ready as the pop strobe.
- Entries below the top live in a synchronous-read RAM array (BRAM-inferable). The top entry is held in a register, so the CPU sees it combinationally.

Parameters:
- X_SIZE, 1024, width of one stack entry in bits (matches the CPU X/Y register width).
- DEPTH, 16, maximum number of entries including the top register; must be ≥2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset, asynchronous, active-low
- push_data_in  input  X_SIZE  value to push (from CPU stack_out)
- push_valid_in  input  1  push request (from CPU stack_out_valid)
- push_ready_out  output  1  stack can accept a push this cycle (to CPU stack_out_ready)
- top_out  output  X_SIZE  current top-of-stack (to CPU stack_in)
- top_valid_out  output  1  top_out holds a valid entry (to CPU stack_in_valid)
- pop_ready_in  input  1  consumer takes top this cycle (from CPU stack_in_ready)
- count_out  output  CNT_W  number of stored entries
- full_out  output  1  count_out == DEPTH
- empty_out  output  1  count_out == 0
- overflow_err_out  output  1  sticky: push attempted while full
- underflow_err_out  output  1  sticky: pop attempted while empty
- clr_err_in  input  1  synchronous clear of both sticky error flags

Behaviour:
- Reset (rst_in low, asynchronous):
  - state=EMPTY, count=0, top register=0, RAM read pointer sp=0.
  - top_valid_out=0, push_ready_out=1, empty_out=1, full_out=0, both error flags 0.
  - RAM contents are not reset.
- Storage layout:
  - The top entry is held in the top register.
  - The entries below it are mem[0..sp-1], with sp = count-1 when count ≥ 1.
- States and transitions:
  - EMPTY: count=0.
    - Push handshake (push_valid_in & push_ready_out): top<=push_data_in, count<=1, go to READY.
    - pop_ready_in: no change except underflow_err_out<=1.
  - READY: top_valid_out=1.
    - Push only: if count<DEPTH, then mem[sp]<=top, sp<=sp+1, top<=push_data_in, count<=count+1. Stay in READY.
    - Pop only (pop_ready_in & top_valid_out), count==1: count<=0, go to EMPTY.
    - Pop only, count>1: issue RAM read of mem[sp-1], sp<=sp-1, count<=count-1, go to REFILL.
    - Push and pop in the same cycle: top<=push_data_in, count unchanged, no RAM access, stay in READY.
  - REFILL: top_valid_out=0 and push_ready_out=0.
    - Next cycle: top<=RAM read data, go to READY.
    - pop_ready_in is ignored; no underflow is flagged.
    - Pop-to-next-top latency is 2 cycles.
- push_ready_out = (count<DEPTH) && state!=REFILL. This is combinational from registered state.
- Push while full (push_valid_in & count==DEPTH): the push is dropped, count is unchanged, overflow_err_out<=1. A same-cycle pop still completes as a normal pop-only.
- top_out always reflects the top register. Its value is don't-care when top_valid_out=0, but it must not glitch while in READY.
- count_out, full_out and empty_out are registered or derived from registered count; no combinational path from inputs.
- Error flags:
  - Sticky until clr_err_in=1 at a clock edge.
  - A clear and a new error event in the same cycle resolve to set.
- A reset asserted mid-REFILL or mid-write abandons the operation. After deassertion the block is in the EMPTY state.
- No combinational path from push_valid_in or pop_ready_in to any output.

Test Plan:
- Reset, then push A=0x1 → the next cycle shows top_out=0x1, top_valid_out=1, count_out=1, empty_out=0.
- Push 0x1, 0x2, 0x3 back-to-back, then pop three times:
  - The pops return 0x3, then 0x2 (after a 1-cycle top_valid_out low), then 0x1.
  - Final count_out=0, empty_out=1.
- With DEPTH=16, push 16 distinct values → full_out=1, push_ready_out=0. Push a 17th → overflow_err_out=1, count_out stays 16, top unchanged. Pulse clr_err_in → overflow_err_out=0.
- Holding 0x5 and 0x6, assert push 0x7 and pop in the same cycle → top_out=0x7, count_out=2, top_valid_out stays 1. A subsequent pop then refills to 0x5.
- When empty, pulse pop_ready_in → underflow_err_out=1, count_out=0, top_valid_out=0.
- Push 0xA, 0xB, pop (entering REFILL), and drop rst_in low during REFILL → outputs immediately return to reset values, and count_out=0 after release.

Source files
------------

// File: rtl/tensor_stack.sv
// tensor_stack: hardware LIFO holding the control unit's operand stack.
// The top entry sits in a register, so the consumer sees it combinationally.
// All entries below the top sit in a synchronous-read RAM (mem[0..sp-1]).
// After a pop, the next top is read from the RAM. This takes one REFILL cycle.
//
// Ports:
//   clk_in, rst_in          clock, async active-low reset
//   push_data_in/valid_in   push request; push_ready_out = can accept
//   top_out/top_valid_out   current top of stack; pop_ready_in = take it
//   count_out/full_out/empty_out   occupancy (registered)
//   overflow_err_out/underflow_err_out   sticky errors, cleared by clr_err_in
module tensor_stack #(
  parameter int X_SIZE = 1024,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [X_SIZE-1:0] push_data_in,
  input  logic              push_valid_in,
  output logic              push_ready_out,
  output logic [X_SIZE-1:0] top_out,
  output logic              top_valid_out,
  input  logic              pop_ready_in,
  output logic [CNT_W-1:0]  count_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_err_out,
  output logic              underflow_err_out,
  input  logic              clr_err_in
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_REFILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [AW-1:0]     r_sp, w_sp_nxt;
  logic [X_SIZE-1:0] r_top, w_top_nxt;
  logic [X_SIZE-1:0] r_rd_data;
  logic [X_SIZE-1:0] mem [2**AW];
  logic              r_ovf, r_unf;
  logic              w_push_fire, w_pop_fire, w_mem_we, w_mem_re;
  logic              w_ovf_evt, w_unf_evt, w_full;

  assign w_full         = (r_count == DEPTH_C);
  assign push_ready_out = !w_full && (r_state != S_REFILL);
  assign top_valid_out  = (r_state == S_READY);
  assign top_out        = r_top;
  assign count_out      = r_count;
  assign full_out       = w_full;
  assign empty_out      = (r_count == '0);
  assign overflow_err_out  = r_ovf;
  assign underflow_err_out = r_unf;

  assign w_push_fire = push_valid_in & push_ready_out;
  assign w_pop_fire  = pop_ready_in & top_valid_out;
  assign w_ovf_evt   = push_valid_in & w_full;
  // A pop during REFILL is ignored, not an underflow. Only a truly empty stack flags.
  assign w_unf_evt   = pop_ready_in & (r_state == S_EMPTY);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_sp_nxt    = r_sp;
    w_top_nxt   = r_top;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push_fire) begin
          w_top_nxt   = push_data_in;
          w_count_nxt = CNT_W'(1);
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (w_push_fire && w_pop_fire) begin
          // Replace the top in place. The RAM is not touched.
          w_top_nxt = push_data_in;
        end else if (w_push_fire) begin
          w_mem_we    = 1'b1;
          w_sp_nxt    = r_sp + 1'b1;
          w_top_nxt   = push_data_in;
          w_count_nxt = r_count + 1'b1;
        end else if (w_pop_fire) begin
          w_count_nxt = r_count - 1'b1;
          if (r_count == CNT_W'(1)) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_mem_re    = 1'b1;
            w_sp_nxt    = r_sp - 1'b1;
            w_state_nxt = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        w_top_nxt   = r_rd_data;
        w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_sp    <= '0;
      r_top   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_sp    <= w_sp_nxt;
      r_top   <= w_top_nxt;
      // A set event wins over a clear in the same cycle.
      r_ovf   <= (r_ovf & ~clr_err_in) | w_ovf_evt;
      r_unf   <= (r_unf & ~clr_err_in) | w_unf_evt;
    end
  end

  // This block has no reset, so a block RAM can be inferred from it.
  always_ff @(posedge clk_in) begin
    if (w_mem_we) mem[r_sp] <= r_top;
    if (w_mem_re) r_rd_data <= mem[w_sp_nxt];
  end
endmodule

// File: tb/tb_tensor_stack.sv
module tb_tensor_stack;
  localparam int XW = 32;
  localparam int D  = 16;
  localparam int CW = $clog2(D+1);

  logic          clk_in = 1'b0, rst_in = 1'b0;
  logic [XW-1:0] push_data_in;
  logic          push_valid_in, push_ready_out;
  logic [XW-1:0] top_out;
  logic          top_valid_out, pop_ready_in;
  logic [CW-1:0] count_out;
  logic          full_out, empty_out, overflow_err_out, underflow_err_out, clr_err_in;

  tensor_stack #(.X_SIZE(XW), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .push_data_in(push_data_in), .push_valid_in(push_valid_in), .push_ready_out(push_ready_out),
    .top_out(top_out), .top_valid_out(top_valid_out), .pop_ready_in(pop_ready_in),
    .count_out(count_out), .full_out(full_out), .empty_out(empty_out),
    .overflow_err_out(overflow_err_out), .underflow_err_out(underflow_err_out),
    .clr_err_in(clr_err_in));

  always #5 clk_in = ~clk_in;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pv, input logic [XW-1:0] pd, input logic pp, input logic clr);
    push_valid_in = pv; push_data_in = pd; pop_ready_in = pp; clr_err_in = clr;
  endtask

  task automatic tick;
    @(posedge clk_in); #1;
  endtask

  // Directed vectors: inputs applied for one edge, expected outputs after it.
  typedef struct {
    logic pv; logic [XW-1:0] pd; logic pp; logic clr;
    logic ev; logic [XW-1:0] et; int ec; logic eu;
  } vec_t;
  vec_t tbl[16];

  function automatic vec_t mk(logic pv, logic [XW-1:0] pd, logic pp, logic clr,
                              logic ev, logic [XW-1:0] et, int ec, logic eu);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pp = pp; v.clr = clr; v.ev = ev; v.et = et; v.ec = ec; v.eu = eu;
    return v;
  endfunction

  // Reference model: a queue of stored values (back = top) plus a refill-bubble flag.
  logic [XW-1:0] q[$];
  bit m_refill, m_ovf, m_unf;

  task automatic model_step(input logic pv, input logic [XW-1:0] pd, input logic pp, input logic clr);
    bit ovf_e = 0, unf_e = 0, acc;
    if (m_refill) begin
      m_refill = 0;
    end else if (q.size() == 0) begin
      if (pp) unf_e = 1;
      if (pv) q.push_back(pd);
    end else begin
      acc = pv && (q.size() < D);
      if (pv && q.size() == D) ovf_e = 1;
      if (acc && pp) q[q.size()-1] = pd;
      else if (acc) q.push_back(pd);
      else if (pp) begin
        void'(q.pop_back());
        if (q.size() > 0) m_refill = 1;
      end
    end
    m_ovf = (m_ovf && !clr) || ovf_e;
    m_unf = (m_unf && !clr) || unf_e;
  endtask

  task automatic model_check;
    bit v;
    v = (q.size() > 0) && !m_refill;
    chk("rnd_valid", 64'(top_valid_out), 64'(v));
    if (v) chk("rnd_top", 64'(top_out), 64'(q[q.size()-1]));
    chk("rnd_count", 64'(count_out), 64'(q.size()));
    chk("rnd_full", 64'(full_out), 64'(q.size() == D));
    chk("rnd_empty", 64'(empty_out), 64'(q.size() == 0));
    chk("rnd_pready", 64'(push_ready_out), 64'((q.size() < D) && !m_refill));
    chk("rnd_ovf", 64'(overflow_err_out), 64'(m_ovf));
    chk("rnd_unf", 64'(underflow_err_out), 64'(m_unf));
  endtask

  initial begin
    tbl[0]  = mk(1, 32'h1, 0, 0, 1, 32'h1, 1, 0);
    tbl[1]  = mk(1, 32'h2, 0, 0, 1, 32'h2, 2, 0);
    tbl[2]  = mk(1, 32'h3, 0, 0, 1, 32'h3, 3, 0);
    tbl[3]  = mk(0, 32'h0, 1, 0, 0, 32'h0, 2, 0);  // pop 3 -> refill bubble
    tbl[4]  = mk(0, 32'h0, 0, 0, 1, 32'h2, 2, 0);
    tbl[5]  = mk(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
    tbl[6]  = mk(0, 32'h0, 0, 0, 1, 32'h1, 1, 0);
    tbl[7]  = mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0);  // last pop, no refill
    tbl[8]  = mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 1);  // pop when empty
    tbl[9]  = mk(0, 32'h0, 0, 1, 0, 32'h0, 0, 0);  // clear underflow
    tbl[10] = mk(1, 32'h5, 0, 0, 1, 32'h5, 1, 0);
    tbl[11] = mk(1, 32'h6, 0, 0, 1, 32'h6, 2, 0);
    tbl[12] = mk(1, 32'h7, 1, 0, 1, 32'h7, 2, 0);  // push+pop replaces top
    tbl[13] = mk(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
    tbl[14] = mk(0, 32'h0, 0, 0, 1, 32'h5, 1, 0);
    tbl[15] = mk(0, 32'h0, 1, 0, 0, 32'h0, 0, 0);

    drive(0, '0, 0, 0);
    #12;
    chk("rst_valid", 64'(top_valid_out), 64'(0));
    chk("rst_pready", 64'(push_ready_out), 64'(1));
    chk("rst_empty", 64'(empty_out), 64'(1));
    chk("rst_full", 64'(full_out), 64'(0));
    chk("rst_count", 64'(count_out), 64'(0));
    chk("rst_top", 64'(top_out), 64'(0));
    chk("rst_errs", 64'({overflow_err_out, underflow_err_out}), 64'(0));
    @(negedge clk_in) rst_in = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].pv, tbl[i].pd, tbl[i].pp, tbl[i].clr);
      tick();
      chk($sformatf("tbl%0d_valid", i), 64'(top_valid_out), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("tbl%0d_top", i), 64'(top_out), 64'(tbl[i].et));
      chk($sformatf("tbl%0d_count", i), 64'(count_out), 64'(tbl[i].ec));
      chk($sformatf("tbl%0d_empty", i), 64'(empty_out), 64'(tbl[i].ec == 0));
      chk($sformatf("tbl%0d_unf", i), 64'(underflow_err_out), 64'(tbl[i].eu));
    end

    // Fill to DEPTH, then overflow handling.
    for (int i = 0; i < D; i++) begin
      drive(1, 32'h100 + 32'(i), 0, 0);
      tick();
      chk("fill_count", 64'(count_out), 64'(i + 1));
    end
    drive(0, '0, 0, 0);
    chk("full_flag", 64'(full_out), 64'(1));
    chk("full_pready", 64'(push_ready_out), 64'(0));
    drive(1, 32'hDEAD, 0, 0); tick();
    chk("ovf_set", 64'(overflow_err_out), 64'(1));
    chk("ovf_count", 64'(count_out), 64'(D));
    chk("ovf_top", 64'(top_out), 64'(32'h10F));
    drive(1, 32'hBEEF, 0, 1); tick();
    chk("ovf_set_wins", 64'(overflow_err_out), 64'(1));
    drive(0, '0, 0, 1); tick();
    chk("ovf_clr", 64'(overflow_err_out), 64'(0));
    drive(1, 32'hCAFE, 1, 0); tick();
    chk("fullpop_count", 64'(count_out), 64'(D - 1));
    chk("fullpop_valid", 64'(top_valid_out), 64'(0));
    chk("fullpop_ovf", 64'(overflow_err_out), 64'(1));
    drive(0, '0, 0, 1); tick();
    chk("fullpop_top", 64'(top_out), 64'(32'h10E));

    // Reset during REFILL.
    rst_in = 1'b0; #2;
    @(negedge clk_in) rst_in = 1'b1;
    drive(1, 32'hA, 0, 0); tick();
    drive(1, 32'hB, 0, 0); tick();
    drive(0, '0, 1, 0); tick();
    chk("refill_valid", 64'(top_valid_out), 64'(0));
    chk("refill_pready", 64'(push_ready_out), 64'(0));
    drive(0, '0, 0, 0);
    #2 rst_in = 1'b0; #1;
    chk("midrst_count", 64'(count_out), 64'(0));
    chk("midrst_valid", 64'(top_valid_out), 64'(0));
    chk("midrst_pready", 64'(push_ready_out), 64'(1));
    chk("midrst_empty", 64'(empty_out), 64'(1));
    chk("midrst_top", 64'(top_out), 64'(0));
    @(negedge clk_in) rst_in = 1'b1;
    tick();
    chk("postrst_count", 64'(count_out), 64'(0));
    chk("postrst_valid", 64'(top_valid_out), 64'(0));

    // Randomized traffic against the queue model (state is empty after reset).
    q.delete(); m_refill = 0; m_ovf = 0; m_unf = 0;
    for (int i = 0; i < 1500; i++) begin
      logic pv, pp, clr;
      logic [XW-1:0] pd;
      int pw;
      pw = ((i / 150) % 2 == 0) ? 80 : 25;
      pv  = ($urandom_range(99) < pw);
      pp  = ($urandom_range(99) < (100 - pw));
      clr = ($urandom_range(15) == 0);
      pd  = $urandom;
      drive(pv, pd, pp, clr);
      model_step(pv, pd, pp, clr);
      tick();
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
